// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing the instruction-memory read port between fetch (0) and debug (1).
// Define IMEM_ARB_STATS_EN to add saturating grant/conflict/error counters as extra outputs.
module imem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_err,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_err,
    input  logic              rsp1_ready,
`ifdef IMEM_ARB_STATS_EN
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       err_cnt,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Highest legal word address; compared at full ADDR_W so high bits cannot alias.
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
    logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
    logic              rsp0_err_q, rsp0_err_d;
    logic              rsp1_err_q, rsp1_err_d;

    logic grant1;
    logic addr_err;
    logic rsp_handshake;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_err_d   = rsp1_err_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        grant1        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        addr_err      = (addr_q[1:0] != 2'b00) || (addr_q > MAX_ADDR);
        rsp_handshake = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready   = ~grant1;
                    req1_ready   = grant1;
                    addr_d       = grant1 ? req1_addr : req0_addr;
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    state_d      = READ;
                end
            end
            READ: begin
                if (owner_q) begin
                    rsp1_data_d = addr_err ? '0 : mem_data;
                    rsp1_err_d  = addr_err;
                end else begin
                    rsp0_data_d = addr_err ? '0 : mem_data;
                    rsp0_err_d  = addr_err;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_handshake) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    assign mem_addr   = addr_q;
    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_err   = rsp1_err_q;

`ifdef IMEM_ARB_STATS_EN
    logic [15:0] grant_cnt0_q, grant_cnt0_d;
    logic [15:0] grant_cnt1_q, grant_cnt1_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        grant_cnt0_d   = grant_cnt0_q;
        grant_cnt1_d   = grant_cnt1_q;
        conflict_cnt_d = conflict_cnt_q;
        err_cnt_d      = err_cnt_q;
        if (req0_ready && grant_cnt0_q != 16'hFFFF) grant_cnt0_d = grant_cnt0_q + 16'd1;
        if (req1_ready && grant_cnt1_q != 16'hFFFF) grant_cnt1_d = grant_cnt1_q + 16'd1;
        if (state_q == IDLE && req0_valid && req1_valid && conflict_cnt_q != 16'hFFFF)
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        if (rsp_handshake && (owner_q ? rsp1_err_q : rsp0_err_q) && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
            err_cnt_q      <= '0;
        end else begin
            grant_cnt0_q   <= grant_cnt0_d;
            grant_cnt1_q   <= grant_cnt1_d;
            conflict_cnt_q <= conflict_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign grant_cnt0   = grant_cnt0_q;
    assign grant_cnt1   = grant_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
    assign err_cnt      = err_cnt_q;
`endif

endmodule
